strength_bus_arbiter: RTL and testbench

Round-robin ownership controller for a shared single-bit wired net that is pulled low by default (pull0) and driven strong by at most one owner at a time. N requesters compete for the line. The block grants exactly one owner, enables that owner's strong driver, and enforces a bounded hold time. It inserts a released turnaround window between owners so that two strong drivers never overlap. It sits between the requesting agents and the wired-net driver stage in the signal-strength test designs.

---
 rtl/strength_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_strength_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/strength_bus_arbiter.sv
// Round-robin owner arbiter for a pull0 wired net: one strong driver at a time,
// bounded hold, and a released turnaround window between consecutive owners.
module strength_bus_arbiter #(
    parameter int N         = 4,
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         drv_data,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 bus_oe,
    output logic                 bus_o,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TA_CYCLES + 1);

    localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TA_LAST  = TW'(TA_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURNAROUND
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [TW-1:0] ta_cnt, ta_n;
    logic          timeout_n;
    logic          busy_n;

    logic [IW-1:0] win;
    logic          found;
    logic [IW-1:0] idx;
    int            idx_i;
    logic          do_arb;

    // First requester at or after ptr, wrapping from N-1 back to 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx_i = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end
            idx = IW'(idx_i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner_id;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        ta_n      = ta_cnt;
        timeout_n = 1'b0;
        do_arb    = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    do_arb = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_id] || (hold_cnt == HOLD_MAX)) begin
                    // Only a still-requesting owner at the hold limit counts as preempted.
                    timeout_n = req[owner_id];
                    state_n   = TURNAROUND;
                    gnt_n     = '0;
                    owner_n   = '0;
                    hold_n    = '0;
                    ta_n      = TW'(1);
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            TURNAROUND: begin
                if (ta_cnt == TA_LAST) begin
                    if (found) begin
                        do_arb = 1'b1;
                    end else begin
                        state_n = IDLE;
                        ta_n    = '0;
                    end
                end else begin
                    ta_n = ta_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                owner_n = '0;
                hold_n  = '0;
                ta_n    = '0;
            end
        endcase

        if (do_arb) begin
            state_n    = GRANT;
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            owner_n    = win;
            hold_n     = HW'(1);
            ta_n       = '0;
            ptr_n      = (win == LAST_ID) ? '0 : win + 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            ta_cnt   <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner_id <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            ta_cnt   <= ta_n;
            timeout  <= timeout_n;
            busy     <= busy_n;
        end
    end

    // The driver enable and line value come only from registered grant state plus live data.
    assign bus_oe = |gnt;
    assign bus_o  = bus_oe ? drv_data[owner_id] : 1'b0;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_timeout_in_ta : assert property (@(posedge clk) disable iff (rst) timeout |-> (state == TURNAROUND));

endmodule

// File: tb/tb_strength_bus_arbiter.sv
// Scoreboard bench for strength_bus_arbiter: expectations derived from the
// intended arbitration behaviour are queued per cycle and compared after each edge.
module tb_strength_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req3, drv_data;

    logic [3:0] gnt, gnt3;
    logic [1:0] owner_id, owner_id3;
    logic       bus_oe, bus_oe3, bus_o, bus_o3, busy, busy3, timeout, timeout3;

    strength_bus_arbiter #(.N(4), .MAX_HOLD(8), .TA_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .drv_data(drv_data),
        .gnt(gnt), .owner_id(owner_id), .bus_oe(bus_oe), .bus_o(bus_o),
        .busy(busy), .timeout(timeout)
    );

    strength_bus_arbiter #(.N(4), .MAX_HOLD(8), .TA_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .drv_data(drv_data),
        .gnt(gnt3), .owner_id(owner_id3), .bus_oe(bus_oe3), .bus_o(bus_o3),
        .busy(busy3), .timeout(timeout3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       oe;
        logic       bus;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    bit    use3  = 1'b0;
    string phase = "reset";

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("[TB] FAIL %s/%s: got %0h expected %0h", phase, tag, obs, want);
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the edge, then compare.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] dd,
                                 input logic [3:0] eg, input logic et, input logic eb);
        exp_t e;
        @(negedge clk);
        rst      = r;
        drv_data = dd;
        if (use3) begin
            req3 = rq;
            req  = 4'b0000;
        end else begin
            req  = rq;
            req3 = 4'b0000;
        end
        e.gnt   = eg;
        e.owner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) e.owner = 2'(i);
        end
        e.oe   = |eg;
        e.bus  = e.oe ? dd[e.owner] : 1'b0;
        e.busy = eb;
        e.tmo  = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (use3) begin
            checkOutput("gnt", 32'(gnt3), 32'(e.gnt));
            checkOutput("owner_id", 32'(owner_id3), 32'(e.owner));
            checkOutput("bus_oe", 32'(bus_oe3), 32'(e.oe));
            checkOutput("bus_o", 32'(bus_o3), 32'(e.bus));
            checkOutput("busy", 32'(busy3), 32'(e.busy));
            checkOutput("timeout", 32'(timeout3), 32'(e.tmo));
        end else begin
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("owner_id", 32'(owner_id), 32'(e.owner));
            checkOutput("bus_oe", 32'(bus_oe), 32'(e.oe));
            checkOutput("bus_o", 32'(bus_o), 32'(e.bus));
            checkOutput("busy", 32'(busy), 32'(e.busy));
            checkOutput("timeout", 32'(timeout), 32'(e.tmo));
        end
    endtask

    initial begin
        logic [3:0] oh;
        rst      = 1'b1;
        req      = 4'b0000;
        req3     = 4'b0000;
        drv_data = 4'b0000;

        phase = "reset";
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);

        phase = "single";
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);

        phase = "rotate";
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b1010, 4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            applyStimulus(1'b0, 4'b1111, 4'b1010, oh, 1'b0, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b0101, oh, 1'b0, 1'b1);
            applyStimulus(1'b0, 4'b1111 & ~oh, 4'b1111, 4'b0000, 1'b0, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1010, 4'b0001 << ((k + 1) % 4), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        phase = "hold_sole";
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1);
            end
            applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        phase = "hold_pair";
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            oh = (r % 2 == 0) ? 4'b0010 : 4'b0100;
            for (int j = 0; j < 8; j++) begin
                applyStimulus(1'b0, 4'b0110, 4'b0100, oh, 1'b0, 1'b1);
            end
            applyStimulus(1'b0, 4'b0110, 4'b0100, 4'b0000, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        phase = "mid_reset";
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 4'b0100, 4'b1111, 4'b0100, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0101, 4'b1111, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);

        phase = "long_ta";
        use3 = 1'b1;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0011, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0010, 4'b0011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b1010, 4'b1011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b1010, 4'b1011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0010, 4'b1011, 4'b0010, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
